// File: rtl/uart_pkg.sv
// UART state encoding shared by the receiver and the future transmitter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package uart_pkg;

    // 3-bit frame-engine states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_DONE   = 3'd5,
        ST_BREAK  = 3'd6
    } uart_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser bringing the asynchronous rxd pin into the clk domain.
// Latency: 2 clk edges from pin to rx_s.
// Backpressure: none; free-running, resets to the idle line level (1).
module uart_rx_sync (
    input  logic clk,
    input  logic rstn,
    input  logic rxd,
    output logic rx_s
);

    logic meta;

    // Metastability stage followed by the stable sample used by the receiver
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            meta <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            meta <= rxd;
            rx_s <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// Oversampling UART receiver: LSB-first frames, optional parity (macro UART_RX_PARITY_EN).
// Latency: rx_valid rises 3 + OSR/2 + (DATA_BITS+1)*OSR (+OSR with parity) edges after start edge.
// Backpressure: rx_valid/rx_data hold until rx_ready; a new word overwrites and pulses overrun.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int OSR        = 8,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 parity_err
);

    localparam int CW = $clog2(OSR);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [CW-1:0] CNT_HALF = CW'(OSR / 2 - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(OSR - 1);
    localparam logic [BW-1:0] BITS_M1  = BW'(DATA_BITS - 1);

    logic                 rx_s;
    uart_state_t          state, state_d;
    logic [CW-1:0]        cntc, cntc_d;
    logic [BW-1:0]        cntb, cntb_d;
    logic [DATA_BITS-1:0] shreg, shreg_d;
    logic [DATA_BITS-1:0] data_d;
    logic                 vld_d;
    logic                 fe_d;
    logic                 ov_d;
    logic                 cntc_zero;

    assign cntc_zero = (cntc == '0);

    uart_rx_sync u_sync (
        .clk  (clk),
        .rstn (rstn),
        .rxd  (rxd),
        .rx_s (rx_s)
    );

`ifdef UART_RX_PARITY_EN
    logic perr_q, perr_d;
    logic pe_d;
    logic par_exp;

    // Expected parity bit for the word in shreg: even sense = XOR of data, odd = inverted
    assign par_exp = (^shreg) ^ PARITY_ODD[0];
`else
    logic unused_par;

    // Parity sense only matters when the parity stage is built in
    assign unused_par = (PARITY_ODD != 0);
    assign parity_err = 1'b0;
`endif

    // Next-state, counter, shift-register and output-pulse decode
    always_comb begin
        state_d = state;
        cntc_d  = cntc;
        cntb_d  = cntb;
        shreg_d = shreg;
        data_d  = rx_data;
        vld_d   = rx_valid & ~rx_ready;
        fe_d    = 1'b0;
        ov_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_d  = perr_q;
        pe_d    = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_d = ST_START;
                    cntc_d  = CNT_HALF;
                end
            end
            ST_START: begin
                if (cntc_zero) begin
                    if (!rx_s) begin
                        state_d = ST_DATA;
                        cntc_d  = CNT_FULL;
                        cntb_d  = BITS_M1;
`ifdef UART_RX_PARITY_EN
                        perr_d  = 1'b0;
`endif
                    end else begin
                        // Start bit not low at mid-bit: treat as a glitch
                        state_d = ST_IDLE;
                    end
                end else begin
                    cntc_d = cntc - CW'(1);
                end
            end
            ST_DATA: begin
                if (cntc_zero) begin
                    shreg_d = {rx_s, shreg[DATA_BITS-1:1]};
                    cntc_d  = CNT_FULL;
                    if (cntb == '0) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        cntb_d = cntb - BW'(1);
                    end
                end else begin
                    cntc_d = cntc - CW'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (cntc_zero) begin
                    perr_d  = rx_s ^ par_exp;
                    state_d = ST_STOP;
                    cntc_d  = CNT_FULL;
                end else begin
                    cntc_d = cntc - CW'(1);
                end
            end
`endif
            ST_STOP: begin
                if (cntc_zero) begin
                    if (rx_s) begin
                        state_d = ST_DONE;
                    end else begin
                        fe_d    = 1'b1;
                        state_d = ST_BREAK;
                    end
                end else begin
                    cntc_d = cntc - CW'(1);
                end
            end
            ST_DONE: begin
                // A word still waiting without an accept this edge is lost
                data_d  = shreg;
                vld_d   = 1'b1;
                ov_d    = rx_valid & ~rx_ready;
`ifdef UART_RX_PARITY_EN
                pe_d    = perr_q;
`endif
                state_d = ST_IDLE;
            end
            ST_BREAK: begin
                // Wait out a held-low line so it does not re-trigger a frame
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered output pulses
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            cntc      <= '0;
            cntb      <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_d;
            cntc      <= cntc_d;
            cntb      <= cntb_d;
            shreg     <= shreg_d;
            rx_data   <= data_d;
            rx_valid  <= vld_d;
            frame_err <= fe_d;
            overrun   <= ov_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    // Parity mismatch latch and its pulse output
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perr_q     <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            perr_q     <= perr_d;
            parity_err <= pe_d;
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param (parity cases built with UART_RX_PARITY_EN).
// Latency: checks the start-edge to rx_valid distance against the frame arithmetic.
// Backpressure: exercises hold, overrun and accept-at-DONE behaviour.
module tb_uart_rx_param;

    localparam int OSR     = 8;
    localparam int DB      = 8;
    localparam int PAR_ODD = 0;
`ifdef UART_RX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int LAT = 3 + OSR / 2 + (DB + 1) * OSR + PAR_BITS * OSR;

    logic          clk = 1'b0;
    logic          rstn;
    logic          rxd;
    logic [DB-1:0] rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          frame_err;
    logic          overrun;
    logic          parity_err;

    int tests = 0;
    int fails = 0;

    int edge_cnt = 0;
    int fe_cnt = 0, ov_cnt = 0, pe_cnt = 0, rise_cnt = 0, last_rise = 0;
    logic prev_vld = 1'b0;
    logic [DB-1:0] got[$];
    logic [DB-1:0] exp_q[$];

    uart_rx_param #(
        .OSR        (OSR),
        .DATA_BITS  (DB),
        .PARITY_ODD (PAR_ODD)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .rxd        (rxd),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Observe outputs mid-cycle: pulse counts, valid rises, accepted words
    always @(negedge clk) begin
        if (frame_err)  fe_cnt++;
        if (overrun)    ov_cnt++;
        if (parity_err) pe_cnt++;
        if (rx_valid && !prev_vld) begin
            rise_cnt++;
            last_rise = edge_cnt;
        end
        prev_vld = rx_valid;
        if (rx_valid && rx_ready) got.push_back(rx_data);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive n line bits, LSB of f first, one bit period each
    task automatic send_bits(input logic [15:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            rxd = f[i];
            wait_edges(OSR);
        end
    endtask

    // Line image of a frame: start, data LSB first, optional parity, stop
    task automatic build_frame(input logic [DB-1:0] d, input logic stop_b, input logic par_bad,
                               output logic [15:0] f, output int n);
        f = '1;
        f[0] = 1'b0;
        for (int i = 0; i < DB; i++) f[1 + i] = d[i];
        n = DB + 1;
`ifdef UART_RX_PARITY_EN
        f[n] = (^d) ^ PAR_ODD[0] ^ par_bad;
        n++;
`else
        if (par_bad) $display("note: parity flip ignored without parity stage");
`endif
        f[n] = stop_b;
        n++;
    endtask

    task automatic send_frame(input logic [DB-1:0] d, input logic stop_b, input logic par_bad);
        logic [15:0] f;
        int n;
        build_frame(d, stop_b, par_bad, f, n);
        send_bits(f, n);
    endtask

    initial begin
        logic [15:0] f;
        int n;
        int e0, r0, fe0, ov0, pe0;
        logic [DB-1:0] d, held;

        // Reset state
        rstn = 1'b0; rxd = 1'b1; rx_ready = 1'b0;
        wait_edges(3);
        chk("rst_valid", 32'(rx_valid), 32'd0);
        chk("rst_data", 32'(rx_data), 32'd0);
        chk("rst_pulses", {29'd0, frame_err, overrun, parity_err}, 32'd0);
        rstn = 1'b1;
        wait_edges(2 * OSR);

        // 0xA5 with latency measurement
        rx_ready = 1'b1;
        got.delete();
        e0 = edge_cnt + 1;
        send_frame(8'hA5, 1'b1, 1'b0);
        wait_edges(4);
        chk("a5_latency", 32'(last_rise - e0), 32'(LAT));
        chk("a5_count", 32'(got.size()), 32'd1);
        if (got.size() > 0) chk("a5_data", 32'(got[0]), 32'hA5);

        // Random words back to back with random idle gaps
        got.delete(); exp_q.delete();
        fe0 = fe_cnt; ov0 = ov_cnt;
        for (int k = 0; k < 8; k++) begin
            d = DB'($urandom);
            exp_q.push_back(d);
            send_frame(d, 1'b1, 1'b0);
            rxd = 1'b1;
            wait_edges($urandom_range(0, 2 * OSR));
        end
        wait_edges(OSR);
        chk("rand_count", 32'(got.size()), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < got.size(); k++)
            chk($sformatf("rand_word%0d", k), 32'(got[k]), 32'(exp_q[k]));
        chk("rand_no_err", 32'((fe_cnt - fe0) + (ov_cnt - ov0)), 32'd0);

        // Bad stop bit, line held low 30 bit periods, then recovery
        got.delete();
        fe0 = fe_cnt; r0 = rise_cnt;
        build_frame(8'h00, 1'b0, 1'b0, f, n);
        send_bits(f, n);
        wait_edges((30 - n) * OSR);
        chk("brk_one_fe", 32'(fe_cnt - fe0), 32'd1);
        chk("brk_no_valid", 32'(rise_cnt - r0), 32'd0);
        rxd = 1'b1;
        wait_edges(2 * OSR);
        send_frame(8'h3C, 1'b1, 1'b0);
        wait_edges(4);
        chk("brk_next_count", 32'(got.size()), 32'd1);
        if (got.size() > 0) chk("brk_next_data", 32'(got[0]), 32'h3C);

        // Short low glitch below half a bit period
        held = rx_data; r0 = rise_cnt; fe0 = fe_cnt;
        rxd = 1'b0;
        wait_edges(3);
        rxd = 1'b1;
        wait_edges(3 * OSR);
        chk("glitch_valid", 32'(rise_cnt - r0), 32'd0);
        chk("glitch_data", 32'(rx_data), 32'(held));
        chk("glitch_fe", 32'(fe_cnt - fe0), 32'd0);

        // Overrun with consumer stalled
        rx_ready = 1'b0;
        ov0 = ov_cnt;
        send_frame(8'h11, 1'b1, 1'b0);
        wait_edges(4);
        chk("ovr_first_vld", 32'(rx_valid), 32'd1);
        chk("ovr_first_data", 32'(rx_data), 32'h11);
        send_frame(8'h22, 1'b1, 1'b0);
        wait_edges(4);
        chk("ovr_pulse", 32'(ov_cnt - ov0), 32'd1);
        chk("ovr_data", 32'(rx_data), 32'h22);

        // Accept coinciding with DONE: new word loaded, no overrun
        ov0 = ov_cnt;
        build_frame(8'h33, 1'b1, 1'b0, f, n);
        send_bits(f, n - 1);
        rxd = 1'b1;
        wait_edges(OSR - 1);
        rx_ready = 1'b1;
        wait_edges(1);
        rx_ready = 1'b0;
        wait_edges(2);
        chk("acc_done_ovr", 32'(ov_cnt - ov0), 32'd0);
        chk("acc_done_vld", 32'(rx_valid), 32'd1);
        chk("acc_done_data", 32'(rx_data), 32'h33);
        rx_ready = 1'b1;
        wait_edges(1);
        chk("acc_clear", 32'(rx_valid), 32'd0);

`ifdef UART_RX_PARITY_EN
        // Parity mismatch still delivers the word; correct parity is silent
        got.delete();
        pe0 = pe_cnt;
        send_frame(8'h07, 1'b1, 1'b1);
        wait_edges(4);
        chk("par_bad_pulse", 32'(pe_cnt - pe0), 32'd1);
        chk("par_bad_data", 32'(got.size() > 0 ? got[0] : 8'hXX), 32'h07);
        got.delete();
        pe0 = pe_cnt;
        send_frame(8'h07, 1'b1, 1'b0);
        wait_edges(4);
        chk("par_ok_pulse", 32'(pe_cnt - pe0), 32'd0);
        chk("par_ok_data", 32'(got.size() > 0 ? got[0] : 8'hXX), 32'h07);
`else
        chk("par_tied", 32'(pe_cnt), 32'd0);
`endif

        // Reset in the middle of the data bits
        fe0 = fe_cnt; ov0 = ov_cnt; pe0 = pe_cnt;
        build_frame(8'h55, 1'b1, 1'b0, f, n);
        send_bits(f, 5);
        rstn = 1'b0;
        rxd = 1'b1;
        wait_edges(2);
        chk("mrst_valid", 32'(rx_valid), 32'd0);
        chk("mrst_data", 32'(rx_data), 32'd0);
        rstn = 1'b1;
        wait_edges(2 * OSR);
        chk("mrst_no_pulse", 32'((fe_cnt - fe0) + (ov_cnt - ov0) + (pe_cnt - pe0)), 32'd0);
        got.delete();
        send_frame(8'hC3, 1'b1, 1'b0);
        wait_edges(4);
        chk("mrst_next_count", 32'(got.size()), 32'd1);
        if (got.size() > 0) chk("mrst_next_data", 32'(got[0]), 32'hC3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
